// File: rtl/alu_unit.sv
// 32-bit EX-stage ALU: combinational result selected by opcode, then registered
// together with the zero and signed-overflow flags (one-cycle latency).
module alu_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       opcode,
  output logic [WIDTH-1:0] alu_out,
  output logic             zf,
  output logic             ov
);

  typedef enum logic [5:0] {
    OP_NOP  = 6'h00,
    OP_ADD  = 6'h01,
    OP_SUB  = 6'h02,
    OP_AND  = 6'h03,
    OP_OR   = 6'h04,
    OP_XOR  = 6'h05,
    OP_NOR  = 6'h06,
    OP_SLL  = 6'h07,
    OP_SRL  = 6'h08,
    OP_SRA  = 6'h09,
    OP_SLT  = 6'h0A,
    OP_SLTU = 6'h0B,
    OP_LUI  = 6'h0C,
    OP_LDW  = 6'h10,
    OP_SDW  = 6'h11
  } op_e;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [4:0]       shamt;
  logic             add_ov;
  logic             sub_ov;
  logic             lt_s;
  logic             lt_u;

  logic [WIDTH-1:0] alu_d, alu_q;
  logic             zf_d, zf_q;
  logic             ov_d, ov_q;

  assign sum    = a + b;
  assign diff   = a - b;
  assign shamt  = b[4:0];
  assign add_ov = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ov = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign lt_s   = $signed(a) < $signed(b);
  assign lt_u   = a < b;

  always_comb begin
    alu_d = '0;
    ov_d  = 1'b0;
    case (opcode)
      OP_ADD, OP_LDW, OP_SDW: begin
        alu_d = sum;
        ov_d  = add_ov;
      end
      OP_SUB: begin
        alu_d = diff;
        ov_d  = sub_ov;
      end
      OP_AND:  alu_d = a & b;
      OP_OR:   alu_d = a | b;
      OP_XOR:  alu_d = a ^ b;
      OP_NOR:  alu_d = ~(a | b);
      OP_SLL:  alu_d = a << shamt;
      OP_SRL:  alu_d = a >> shamt;
      OP_SRA:  alu_d = $unsigned($signed(a) >>> shamt);
      OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: alu_d = {{(WIDTH-1){1'b0}}, lt_u};
      OP_LUI:  alu_d = {b[15:0], {(WIDTH-16){1'b0}}};
      default: begin
        alu_d = '0;
        ov_d  = 1'b0;
      end
    endcase
    zf_d = (alu_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q <= '0;
      zf_q  <= 1'b1;
      ov_q  <= 1'b0;
    end else begin
      alu_q <= alu_d;
      zf_q  <= zf_d;
      ov_q  <= ov_d;
    end
  end

  assign alu_out = alu_q;
  assign zf      = zf_q;
  assign ov      = ov_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: each step pushes its expected result on a
// scoreboard queue, which is popped and checked one edge later.
module tb_alu_unit;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [5:0]  opcode;
  logic [31:0] alu_out;
  logic        zf;
  logic        ov;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        z;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  alu_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .opcode  (opcode),
    .alu_out (alu_out),
    .zf      (zf),
    .ov      (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [5:0] op, input logic [31:0] ia,
                      input logic [31:0] ib, input string tag, input logic [31:0] eres,
                      input logic ez, input logic eo);
    exp_t e;
    exp_t got;
    rst    = r;
    opcode = op;
    a      = ia;
    b      = ib;
    e.tag  = tag;
    e.res  = eres;
    e.z    = ez;
    e.o    = eo;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_cmp++;
    assert (sb.size() == 1) else begin
      n_err++;
      $error("FAIL %s scoreboard depth got %0d want 1", tag, sb.size());
    end
    if (sb.size() != 0) begin
      got = sb.pop_front();
      n_cmp++;
      assert (alu_out === got.res) else begin
        n_err++;
        $error("FAIL %s alu_out got %h want %h", got.tag, alu_out, got.res);
      end
      n_cmp++;
      assert (zf === got.z) else begin
        n_err++;
        $error("FAIL %s zf got %b want %b", got.tag, zf, got.z);
      end
      n_cmp++;
      assert (ov === got.o) else begin
        n_err++;
        $error("FAIL %s ov got %b want %b", got.tag, ov, got.o);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    opcode = '0;
    a      = '0;
    b      = '0;

    // reset has priority over a live opcode
    step(1'b1, 6'h01, 32'd5, 32'd7, "reset0", 32'h0, 1'b1, 1'b0);
    step(1'b1, 6'h01, 32'h7FFFFFFF, 32'd1, "reset1", 32'h0, 1'b1, 1'b0);
    step(1'b0, 6'h01, 32'd5, 32'd7, "add_5_7", 32'h0000000C, 1'b0, 1'b0);

    step(1'b0, 6'h01, 32'h7FFFFFFF, 32'd1, "add_ov", 32'h80000000, 1'b0, 1'b1);
    step(1'b0, 6'h01, 32'hFFFFFFFF, 32'd1, "add_carry_no_ov", 32'h0, 1'b1, 1'b0);
    step(1'b0, 6'h02, 32'd3, 32'd3, "sub_zero", 32'h0, 1'b1, 1'b0);
    step(1'b0, 6'h02, 32'h80000000, 32'd1, "sub_ov_neg", 32'h7FFFFFFF, 1'b0, 1'b1);
    step(1'b0, 6'h02, 32'h7FFFFFFF, 32'hFFFFFFFF, "sub_ov_pos", 32'h80000000, 1'b0, 1'b1);

    step(1'b0, 6'h03, 32'hF0F0F0F0, 32'h0FF00FF0, "and", 32'h00F000F0, 1'b0, 1'b0);
    step(1'b0, 6'h04, 32'hF0F0F0F0, 32'h0FF00FF0, "or",  32'hFFF0FFF0, 1'b0, 1'b0);
    step(1'b0, 6'h05, 32'hF0F0F0F0, 32'h0FF00FF0, "xor", 32'hFF00FF00, 1'b0, 1'b0);
    step(1'b0, 6'h06, 32'hF0F0F0F0, 32'h0FF00FF0, "nor", 32'h000F000F, 1'b0, 1'b0);

    step(1'b0, 6'h07, 32'h80000001, 32'd4, "sll4", 32'h00000010, 1'b0, 1'b0);
    step(1'b0, 6'h08, 32'h80000001, 32'd4, "srl4", 32'h08000000, 1'b0, 1'b0);
    step(1'b0, 6'h09, 32'h80000001, 32'd4, "sra4", 32'hF8000000, 1'b0, 1'b0);
    step(1'b0, 6'h09, 32'h80000001, 32'h24, "sra_b24", 32'hF8000000, 1'b0, 1'b0);
    step(1'b0, 6'h07, 32'h12345678, 32'd0, "sll0", 32'h12345678, 1'b0, 1'b0);
    step(1'b0, 6'h08, 32'h12345678, 32'h20, "srl_b20", 32'h12345678, 1'b0, 1'b0);
    step(1'b0, 6'h08, 32'h80000000, 32'd31, "srl31", 32'h00000001, 1'b0, 1'b0);
    step(1'b0, 6'h09, 32'h80000000, 32'd31, "sra31", 32'hFFFFFFFF, 1'b0, 1'b0);

    step(1'b0, 6'h0A, 32'hFFFFFFFF, 32'd1, "slt_neg", 32'd1, 1'b0, 1'b0);
    step(1'b0, 6'h0B, 32'hFFFFFFFF, 32'd1, "sltu_big", 32'd0, 1'b1, 1'b0);
    step(1'b0, 6'h0A, 32'd1, 32'hFFFFFFFF, "slt_pos", 32'd0, 1'b1, 1'b0);
    step(1'b0, 6'h0B, 32'd1, 32'hFFFFFFFF, "sltu_small", 32'd1, 1'b0, 1'b0);
    step(1'b0, 6'h0C, 32'hDEADBEEF, 32'hABCD1234, "lui", 32'h12340000, 1'b0, 1'b0);

    step(1'b0, 6'h10, 32'h00001000, 32'hFFFFFFFC, "ldw", 32'h00000FFC, 1'b0, 1'b0);
    step(1'b0, 6'h11, 32'h7FFFFFF0, 32'h00000010, "sdw_ov", 32'h80000000, 1'b0, 1'b1);
    step(1'b0, 6'h10, 32'h80000000, 32'h80000000, "ldw_ov", 32'h00000000, 1'b1, 1'b1);

    step(1'b0, 6'h00, 32'd1, 32'd1, "nop", 32'h0, 1'b1, 1'b0);
    step(1'b0, 6'h3F, 32'd5, 32'd7, "undef3f", 32'h0, 1'b1, 1'b0);
    step(1'b0, 6'h0D, 32'h7FFFFFFF, 32'd1, "undef0d", 32'h0, 1'b1, 1'b0);
    step(1'b0, 6'h12, 32'h7FFFFFFF, 32'd1, "undef12", 32'h0, 1'b1, 1'b0);

    // back-to-back stream interrupted by reset, then resumed
    step(1'b0, 6'h01, 32'd10, 32'd20, "b2b_add", 32'd30, 1'b0, 1'b0);
    step(1'b0, 6'h02, 32'd10, 32'd20, "b2b_sub", 32'hFFFFFFF6, 1'b0, 1'b0);
    step(1'b1, 6'h01, 32'd5, 32'd7, "mid_reset", 32'h0, 1'b1, 1'b0);
    step(1'b0, 6'h05, 32'hAAAA5555, 32'h5555AAAA, "after_reset", 32'hFFFFFFFF, 1'b0, 1'b0);
    step(1'b0, 6'h01, 32'd5, 32'd7, "b2b_last", 32'h0000000C, 1'b0, 1'b0);

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL sb_drain leftover got %0d want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
